bias_relu_pool: RTL and testbench
=================================

BIAS_RELU_POOL -- requirements
Module: bias_relu_pool

Interface
REQ-001 SHALL have parameter fm_size, default 4, meaning input feature-map edge; it must be even and ≥2.
REQ-002 SHALL have derived localparam ps = fm_size/2, meaning the pooled map edge.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: the upstream "resting" flag; a rising edge requests a run.
REQ-006 SHALL have ports IK1, IK2, IK3, input, 16*fm_size*fm_size bits each: Q1.15 partial feature maps, one per channel.
REQ-007 In IK1..IK3, element (r,c) SHALL sit at bits [16k+15:16k], where k = r*fm_size + c.
REQ-008 SHALL have ports B1, B2, B3, input, 16 bits each: Q1.15 per-channel bias.
REQ-009 SHALL have ports P1, P2, P3, output, 16*ps*ps bits each: pooled maps, element (pr,pc) at index pr*ps + pc, same packing as REQ-007.
REQ-010 SHALL have port busy, output, 1 bit: high while pooling.
REQ-011 SHALL have port done, output, 1 bit: high after a completed run.

Function
REQ-012 SHALL register start into start_q every cycle; accepted edge = start & ~start_q while in IDLE.
REQ-013 SHALL implement an FSM with states IDLE, POOL, DONE.
REQ-014 IDLE→POOL on an accepted edge (cycle T0): snapshot IK1..3 and B1..3 into internal registers, set idx=0, busy=1, done=0.
REQ-015 In POOL, SHALL write one pooled position per cycle for all 3 channels in parallel, in row-major order over idx = 0..ps*ps-1, at edges T1..T(ps*ps).
REQ-016 At edge T(ps*ps), SHALL go POOL→DONE with done=1 and busy=0; total latency from T0 to done = ps*ps cycles.
REQ-017 DONE→POOL on an accepted edge (same actions as REQ-014); otherwise SHALL stay in DONE with done held at 1.
REQ-018 Start edges while in POOL SHALL be ignored, with no restart; start_q still tracks start.
REQ-019 A start held high continuously SHALL trigger only one run.
REQ-020 Arithmetic per element: s = x + b computed at 17 bits signed, saturated to [-32768, 32767].
REQ-021 Per window (rows 2pr..2pr+1, cols 2pc..2pc+1): out = max(0, max of the four saturated s); result range [0, 32767].
REQ-022 Output computation SHALL use only the snapshot; changes on IK/B during POOL SHALL have no effect.
REQ-023 P outputs SHALL be registered and hold their last values until overwritten by a later run; positions not yet written in the current run keep prior-run values.

Reset
REQ-024 With rst high at a rising edge, SHALL force: state IDLE, idx 0, start_q 0, busy 0, done 0, all P1..P3 elements 0, snapshot 0.
REQ-025 Reset mid-POOL SHALL abort the run with no further writes, and done SHALL stay 0.
REQ-026 After reset release, SHALL wait for a start edge; if start is already high, start_q=0 makes it accepted on the first non-reset edge.

Structure
REQ-027 A shared package SHALL hold Q1.15 constants (Q_MAX=32767, Q_MIN=-32768), the FSM state typedef, and a saturating-add function.
REQ-028 SHALL contain one sub-module, pool_window, instantiated 3 times (once per channel): combinational, taking four 16-bit values and bias and producing the REQ-021 result.
REQ-029 The top module SHALL hold the FSM, idx counter, snapshot registers and output registers.

Verification
REQ-030 fm_size=4, IK1 = k*256 for element k (0..15), B1=0, start 0→1: at T4 P1 = {1280, 1792, 3328, 3840}, done=1, busy had been high for exactly 4 cycles.
REQ-031 All IK2 elements = -1000, B2 = 500 → P2 all 0 (ReLU); IK3 all 30000, B3 = 10000 → P3 all 32767 (saturation).
REQ-032 IK1 = -32768 everywhere, B1 = -1 → s saturates to -32768 → P1 all 0.
REQ-033 Start held high across two runs' worth of time → exactly one run; a second 0→1 pulse during POOL → ignored; a pulse after done → new run, with done dropping at T0.
REQ-034 rst asserted at T2 of a run → next cycle P all 0, busy 0, done 0; a new start edge then completes normally in 4 cycles.
REQ-035 Change IK1 at T1 during POOL → P1 matches the T0 snapshot values.

Source files
------------

// File: rtl/bias_relu_pool_pkg.sv
// Shared Q1.15 constants, FSM state type and saturating add for bias_relu_pool.
package bias_relu_pool_pkg;

  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;   //  32767
  localparam logic signed [15:0] Q_MIN = 16'sh8000;   // -32768

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POOL = 2'd1,
    DONE = 2'd2
  } state_t;

  // 17-bit signed add; overflow shows up as the two top bits disagreeing.
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) begin
      return s[16] ? Q_MIN : Q_MAX;
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/bias_relu_pool_pool_window.sv
// One 2x2 pooling window: add bias with saturation, take the max, clamp at zero.
module pool_window
  import bias_relu_pool_pkg::*;
(
  input  logic signed [15:0] x0,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] x3,
  input  logic signed [15:0] bias,
  output logic        [15:0] y
);

  logic signed [15:0] s0, s1, s2, s3;
  logic signed [15:0] m01, m23, m;

  // Biased elements, max of four, then ReLU (a negative max becomes zero).
  always_comb begin
    s0  = sat_add(x0, bias);
    s1  = sat_add(x1, bias);
    s2  = sat_add(x2, bias);
    s3  = sat_add(x3, bias);
    m01 = (s0 > s1) ? s0 : s1;
    m23 = (s2 > s3) ? s2 : s3;
    m   = (m01 > m23) ? m01 : m23;
    y   = m[15] ? 16'd0 : m;
  end

endmodule

// File: rtl/bias_relu_pool.sv
// Bias + ReLU + 2x2 max-pool over three channels, one pooled position per cycle.
//
// state | meaning
// IDLE  | after reset, waiting for a start rising edge
// POOL  | writing pooled position idx for all channels, one per cycle
// DONE  | run finished, done held high, a new start edge restarts
module bias_relu_pool
  import bias_relu_pool_pkg::*;
#(
  parameter int fm_size = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [16*fm_size*fm_size-1:0]   IK1,
  input  logic [16*fm_size*fm_size-1:0]   IK2,
  input  logic [16*fm_size*fm_size-1:0]   IK3,
  input  logic [15:0]                     B1,
  input  logic [15:0]                     B2,
  input  logic [15:0]                     B3,
  output logic [16*(fm_size/2)*(fm_size/2)-1:0] P1,
  output logic [16*(fm_size/2)*(fm_size/2)-1:0] P2,
  output logic [16*(fm_size/2)*(fm_size/2)-1:0] P3,
  output logic                            busy,
  output logic                            done
);

  localparam int ps = fm_size / 2;
  localparam int NP = ps * ps;
  localparam int NE = fm_size * fm_size;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  state_t          state, state_n;
  logic            start_q;
  logic [IW-1:0]   idx;
  logic [16*NE-1:0] snap1, snap2, snap3;
  logic [15:0]     sb1, sb2, sb3;
  logic            edge_seen, load, wr, last;
  logic [15:0]     w1 [4];
  logic [15:0]     w2 [4];
  logic [15:0]     w3 [4];
  logic [15:0]     y1, y2, y3;

  assign edge_seen = start & ~start_q;
  assign last      = (idx == IW'(NP - 1));
  assign busy      = (state == POOL);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus snapshot-load and position-write strobes.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        if (edge_seen) begin
          load    = 1'b1;
          state_n = POOL;
        end
      end
      POOL: begin
        wr = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (edge_seen) begin
          load    = 1'b1;
          state_n = POOL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gather the four snapshot elements of window idx (row-major over the pooled map).
  always_comb begin
    int pr, pc, k0;
    pr = int'(idx) / ps;
    pc = int'(idx) % ps;
    k0 = 2 * pr * fm_size + 2 * pc;
    w1[0] = snap1[16*k0 +: 16];
    w1[1] = snap1[16*(k0+1) +: 16];
    w1[2] = snap1[16*(k0+fm_size) +: 16];
    w1[3] = snap1[16*(k0+fm_size+1) +: 16];
    w2[0] = snap2[16*k0 +: 16];
    w2[1] = snap2[16*(k0+1) +: 16];
    w2[2] = snap2[16*(k0+fm_size) +: 16];
    w2[3] = snap2[16*(k0+fm_size+1) +: 16];
    w3[0] = snap3[16*k0 +: 16];
    w3[1] = snap3[16*(k0+1) +: 16];
    w3[2] = snap3[16*(k0+fm_size) +: 16];
    w3[3] = snap3[16*(k0+fm_size+1) +: 16];
  end

  pool_window u_win1 (.x0(w1[0]), .x1(w1[1]), .x2(w1[2]), .x3(w1[3]), .bias(sb1), .y(y1));
  pool_window u_win2 (.x0(w2[0]), .x1(w2[1]), .x2(w2[2]), .x3(w2[3]), .bias(sb2), .y(y2));
  pool_window u_win3 (.x0(w3[0]), .x1(w3[1]), .x2(w3[2]), .x3(w3[3]), .bias(sb3), .y(y3));

  // Start edge tracking, snapshot capture, position counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      idx     <= '0;
      snap1   <= '0;
      snap2   <= '0;
      snap3   <= '0;
      sb1     <= '0;
      sb2     <= '0;
      sb3     <= '0;
      P1      <= '0;
      P2      <= '0;
      P3      <= '0;
    end else begin
      start_q <= start;
      if (load) begin
        snap1 <= IK1;
        snap2 <= IK2;
        snap3 <= IK3;
        sb1   <= B1;
        sb2   <= B2;
        sb3   <= B3;
        idx   <= '0;
      end else if (wr) begin
        P1[16*int'(idx) +: 16] <= y1;
        P2[16*int'(idx) +: 16] <= y2;
        P3[16*int'(idx) +: 16] <= y3;
        idx <= last ? '0 : idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bias_relu_pool.sv
// Self-checking bench for bias_relu_pool at fm_size=4.
module tb_bias_relu_pool;

  localparam int FM = 4;
  localparam int PS = FM / 2;
  localparam int IKW = 16 * FM * FM;
  localparam int PW = 16 * PS * PS;

  logic           clk, rst, start;
  logic [IKW-1:0] ik1, ik2, ik3;
  logic [15:0]    b1, b2, b3;
  logic [PW-1:0]  p1, p2, p3;
  logic           busy, done;

  int tests = 0;
  int fails = 0;

  bias_relu_pool #(.fm_size(FM)) dut (
    .clk(clk), .rst(rst), .start(start),
    .IK1(ik1), .IK2(ik2), .IK3(ik3),
    .B1(b1), .B2(b2), .B3(b3),
    .P1(p1), .P2(p2), .P3(p3),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [IKW-1:0] i1, i2, i3;
    logic [15:0]    c1, c2, c3;
    logic [PW-1:0]  e1, e2, e3;
  } vec_t;

  vec_t vecs[6];

  // Reference: per pooled cell, max over the window of clamp(x+b), starting at 0 for ReLU.
  function automatic logic [PW-1:0] model(input logic [IKW-1:0] ik, input logic [15:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int pr = 0; pr < PS; pr++) begin
      for (int pc = 0; pc < PS; pc++) begin
        int m;
        m = 0;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            int k, s;
            logic signed [15:0] x, bb;
            k  = (2*pr + dr) * FM + 2*pc + dc;
            x  = ik[16*k +: 16];
            bb = b;
            s  = int'(x) + int'(bb);
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            if (s > m) m = s;
          end
        end
        r[16*(pr*PS + pc) +: 16] = m[15:0];
      end
    end
    return r;
  endfunction

  function automatic logic [IKW-1:0] fill(input logic [15:0] v);
    logic [IKW-1:0] r;
    for (int k = 0; k < FM*FM; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [IKW-1:0] rand_ik();
    logic [IKW-1:0] r;
    for (int k = 0; k < FM*FM; k++) r[16*k +: 16] = 16'($urandom);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Runs one job; fresh=1 gives start a clean 0->1, drop=1 lowers start after done,
  // scramble=1 changes all inputs right after the snapshot edge.
  task automatic run_check(input string nm, input bit fresh, input bit drop, input bit scramble,
                           input logic [PW-1:0] e1, input logic [PW-1:0] e2,
                           input logic [PW-1:0] e3);
    int bc;
    bit got, d0, b0;
    if (fresh) begin
      start = 1'b0;
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    d0 = done;
    b0 = busy;
    if (scramble) begin
      ik1 = rand_ik(); ik2 = rand_ik(); ik3 = rand_ik();
      b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom);
    end
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    check({nm, " done_low_at_T0"}, 64'(d0), 64'd0);
    check({nm, " busy_high_at_T0"}, 64'(b0), 64'd1);
    check({nm, " done"}, 64'(got), 64'd1);
    check({nm, " busy_cycles"}, 64'(bc), 64'd4);
    check({nm, " busy_low_at_done"}, 64'(busy), 64'd0);
    check({nm, " P1"}, 64'(p1), 64'(e1));
    check({nm, " P2"}, 64'(p2), 64'(e2));
    check({nm, " P3"}, 64'(p3), 64'(e3));
    if (drop) start = 1'b0;
  endtask

  initial begin
    logic [IKW-1:0] s1, s2, s3;
    logic [15:0]    t1, t2, t3;
    int bc;

    // Vector table: directed cases with literal expectations, random ones via the model.
    for (int k = 0; k < FM*FM; k++) vecs[0].i1[16*k +: 16] = 16'(k * 256);
    vecs[0].c1 = 16'd0;
    vecs[0].i2 = fill(-16'sd1000);  vecs[0].c2 = 16'd500;
    vecs[0].i3 = fill(16'd30000);   vecs[0].c3 = 16'd10000;
    vecs[0].e1 = {16'd3840, 16'd3328, 16'd1792, 16'd1280};
    vecs[0].e2 = '0;
    vecs[0].e3 = {4{16'd32767}};
    vecs[1].i1 = fill(16'h8000);    vecs[1].c1 = 16'hFFFF;
    vecs[1].i2 = fill(16'd32767);   vecs[1].c2 = 16'd32767;
    vecs[1].i3 = fill(16'd100);     vecs[1].c3 = -16'sd50;
    vecs[1].e1 = '0;
    vecs[1].e2 = {4{16'd32767}};
    vecs[1].e3 = {4{16'd50}};
    for (int v = 2; v < 6; v++) begin
      vecs[v].i1 = rand_ik(); vecs[v].i2 = rand_ik(); vecs[v].i3 = rand_ik();
      vecs[v].c1 = 16'($urandom); vecs[v].c2 = 16'($urandom); vecs[v].c3 = 16'($urandom);
      vecs[v].e1 = model(vecs[v].i1, vecs[v].c1);
      vecs[v].e2 = model(vecs[v].i2, vecs[v].c2);
      vecs[v].e3 = model(vecs[v].i3, vecs[v].c3);
    end

    rst = 1'b1; start = 1'b0;
    ik1 = '0; ik2 = '0; ik3 = '0; b1 = '0; b2 = '0; b3 = '0;
    repeat (3) @(negedge clk);
    check("reset P1", 64'(p1), 64'd0);
    check("reset P2", 64'(p2), 64'd0);
    check("reset P3", 64'(p3), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      ik1 = vecs[v].i1; ik2 = vecs[v].i2; ik3 = vecs[v].i3;
      b1 = vecs[v].c1; b2 = vecs[v].c2; b3 = vecs[v].c3;
      run_check($sformatf("vec%0d", v), 1'b1, 1'b1, 1'b0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
    end

    // Start held high: one run only.
    ik1 = vecs[0].i1; ik2 = vecs[0].i2; ik3 = vecs[0].i3;
    b1 = vecs[0].c1; b2 = vecs[0].c2; b3 = vecs[0].c3;
    run_check("held", 1'b1, 1'b0, 1'b0, vecs[0].e1, vecs[0].e2, vecs[0].e3);
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("held no_rerun", 64'(bc), 64'd0);
    check("held done_kept", 64'(done), 64'd1);

    // Second 0->1 pulse inside POOL is ignored.
    ik1 = vecs[2].i1; ik2 = vecs[2].i2; ik3 = vecs[2].i3;
    b1 = vecs[2].c1; b2 = vecs[2].c2; b3 = vecs[2].c3;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (i == 1) start = 1'b0;
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
    end
    check("pulse_in_pool busy_cycles", 64'(bc), 64'd4);
    check("pulse_in_pool done", 64'(done), 64'd1);
    check("pulse_in_pool P1", 64'(p1), 64'(vecs[2].e1));

    // Pulse after done starts a new run.
    ik1 = vecs[1].i1; ik2 = vecs[1].i2; ik3 = vecs[1].i3;
    b1 = vecs[1].c1; b2 = vecs[1].c2; b3 = vecs[1].c3;
    run_check("after_done", 1'b1, 1'b1, 1'b0, vecs[1].e1, vecs[1].e2, vecs[1].e3);

    // Reset at T2 aborts; start held through reset is taken on the first free edge.
    ik1 = vecs[3].i1; ik2 = vecs[3].i2; ik3 = vecs[3].i3;
    b1 = vecs[3].c1; b2 = vecs[3].c2; b3 = vecs[3].c3;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midreset P1", 64'(p1), 64'd0);
    check("midreset P2", 64'(p2), 64'd0);
    check("midreset P3", 64'(p3), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ik1 = vecs[4].i1; ik2 = vecs[4].i2; ik3 = vecs[4].i3;
    b1 = vecs[4].c1; b2 = vecs[4].c2; b3 = vecs[4].c3;
    run_check("post_reset", 1'b0, 1'b1, 1'b0, vecs[4].e1, vecs[4].e2, vecs[4].e3);

    // Inputs changed right after the snapshot edge must not matter.
    s1 = rand_ik(); s2 = rand_ik(); s3 = rand_ik();
    t1 = 16'($urandom); t2 = 16'($urandom); t3 = 16'($urandom);
    ik1 = s1; ik2 = s2; ik3 = s3; b1 = t1; b2 = t2; b3 = t3;
    run_check("snapshot", 1'b1, 1'b1, 1'b1, model(s1, t1), model(s2, t2), model(s3, t3));

    // Extra random runs against the model.
    for (int r = 0; r < 6; r++) begin
      s1 = rand_ik(); s2 = rand_ik(); s3 = rand_ik();
      t1 = 16'($urandom); t2 = 16'($urandom); t3 = 16'($urandom);
      ik1 = s1; ik2 = s2; ik3 = s3; b1 = t1; b2 = t2; b3 = t3;
      run_check($sformatf("rand%0d", r), 1'b1, 1'b1, 1'b0,
                model(s1, t1), model(s2, t2), model(s3, t3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
